// File: rtl/dmem_mmio.sv
// Data-side memory responder for the single-cycle cpu: word RAM plus a 16-word MMIO page
// (output port, synchronized input, cycle counter, auto-reload timer, RAM write counter).
module dmem_mmio #(
  parameter int DWIDTH    = 8,
  parameter int RAM_DEPTH = 192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [DWIDTH-1:0] aluout,
  input  logic [DWIDTH-1:0] writedata,
  output logic [DWIDTH-1:0] readdata,
  input  logic [DWIDTH-1:0] io_in,
  output logic [DWIDTH-1:0] io_out,
  output logic              timer_irq
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [DWIDTH:0] RAM_END = (DWIDTH+1)'(RAM_DEPTH);

  localparam logic [3:0] OFS_OUT    = 4'd0;
  localparam logic [3:0] OFS_IN     = 4'd1;
  localparam logic [3:0] OFS_CYCLE  = 4'd2;
  localparam logic [3:0] OFS_RELOAD = 4'd3;
  localparam logic [3:0] OFS_COUNT  = 4'd4;
  localparam logic [3:0] OFS_STATUS = 4'd5;
  localparam logic [3:0] OFS_WRCNT  = 4'd6;

  localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);

  logic [DWIDTH-1:0] ram [RAM_DEPTH];

  logic [DWIDTH-1:0] out_q;
  logic [DWIDTH-1:0] sync1_q;
  logic [DWIDTH-1:0] sync2_q;
  logic [DWIDTH-1:0] cycle_q;
  logic [DWIDTH-1:0] reload_q;
  logic [DWIDTH-1:0] count_q;
  logic [DWIDTH-1:0] wrcnt_q;
  logic              flag_q;

  logic          in_ram;
  logic          in_mmio;
  logic [3:0]    ofs;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          out_we;
  logic          reload_we;
  logic          status_clr;
  logic          expire;

  // RAM and MMIO regions never overlap because RAM_DEPTH stays below the MMIO base.
  assign in_ram  = {1'b0, aluout} < RAM_END;
  assign in_mmio = &aluout[DWIDTH-1:4];
  assign ofs     = aluout[3:0];
  assign ram_idx = aluout[AW-1:0];

  assign ram_we     = memwrite & in_ram;
  assign out_we     = memwrite & in_mmio & (ofs == OFS_OUT);
  assign reload_we  = memwrite & in_mmio & (ofs == OFS_RELOAD);
  assign status_clr = memwrite & in_mmio & (ofs == OFS_STATUS) & writedata[0];

  // A reload write wins over the 1->0 transition, so no expiry can coincide with it.
  assign expire = ~reload_we & (count_q == ONE);

  // RAM contents survive reset; only the write is blocked while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && ram_we) begin
      ram[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cycle_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      cycle_q <= cycle_q + ONE;
      if (out_we) begin
        out_q <= writedata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrcnt_q <= '0;
    end else if (ram_we && (wrcnt_q != '1)) begin
      wrcnt_q <= wrcnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      count_q  <= '0;
    end else if (reload_we) begin
      reload_q <= writedata;
      count_q  <= writedata;
    end else if (expire) begin
      count_q <= reload_q;
    end else if (count_q != '0) begin
      count_q <= count_q - ONE;
    end
  end

  // Set beats a same-edge W1C clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= expire | (flag_q & ~status_clr);
    end
  end

  always_comb begin
    readdata = '0;
    if (in_ram) begin
      readdata = ram[ram_idx];
    end else if (in_mmio) begin
      case (ofs)
        OFS_OUT:    readdata = out_q;
        OFS_IN:     readdata = sync2_q;
        OFS_CYCLE:  readdata = cycle_q;
        OFS_RELOAD: readdata = reload_q;
        OFS_COUNT:  readdata = count_q;
        OFS_STATUS: readdata = {{(DWIDTH-1){1'b0}}, flag_q};
        OFS_WRCNT:  readdata = wrcnt_q;
        default:    readdata = '0;
      endcase
    end
  end

  assign io_out    = out_q;
  assign timer_irq = flag_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus random traffic compared
// against a per-edge behavioural model of the memory map.
module tb_dmem_mmio;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] aluout = 8'h00;
  logic [7:0] writedata = 8'h00;
  logic [7:0] io_in = 8'h00;
  logic [7:0] readdata;
  logic [7:0] io_out;
  logic       timer_irq;

  dmem_mmio #(.DWIDTH(8), .RAM_DEPTH(192)) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .aluout(aluout),
    .writedata(writedata),
    .readdata(readdata),
    .io_in(io_in),
    .io_out(io_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  logic [7:0] m_ram [256];
  bit         m_valid [256];
  logic [7:0] m_out, m_s1, m_s2, m_cyc, m_rel, m_cnt, m_wrc;
  bit         m_flag;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00; m_cyc = 8'h00;
    m_rel = 8'h00; m_cnt = 8'h00; m_wrc = 8'h00; m_flag = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a < 8'd192) return m_ram[a];
    case (a)
      8'hF0:   return m_out;
      8'hF1:   return m_s2;
      8'hF2:   return m_cyc;
      8'hF3:   return m_rel;
      8'hF4:   return m_cnt;
      8'hF5:   return {7'b0, m_flag};
      8'hF6:   return m_wrc;
      default: return 8'h00;
    endcase
  endfunction

  // One rising edge of the memory map, expressed from the address-map rules.
  task automatic m_edge(input bit we, input logic [7:0] a, input logic [7:0] wd, input logic [7:0] inv);
    bit expire;
    expire = 1'b0;
    m_s2 = m_s1;
    m_s1 = inv;
    m_cyc = m_cyc + 8'd1;
    if (we && a < 8'd192) begin
      m_ram[a] = wd;
      m_valid[a] = 1'b1;
      if (m_wrc != 8'hFF) m_wrc = m_wrc + 8'd1;
    end
    if (we && a == 8'hF0) m_out = wd;
    if (we && a == 8'hF3) begin
      m_rel = wd;
      m_cnt = wd;
    end else if (m_cnt != 8'h00) begin
      m_cnt = m_cnt - 8'd1;
      if (m_cnt == 8'h00) begin
        expire = 1'b1;
        m_cnt = m_rel;
      end
    end
    if (expire) m_flag = 1'b1;
    else if (we && a == 8'hF5 && wd[0]) m_flag = 1'b0;
  endtask

  // Drive one cpu access for a full cycle; checks pre-edge read data and outputs at the negedge.
  task automatic do_op(input bit we, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] inv, output logic [7:0] rd);
    memwrite = we;
    aluout = a;
    writedata = wd;
    io_in = inv;
    @(negedge clk);
    rd = readdata;
    if (a >= 8'd192 || m_valid[a]) check_eq($sformatf("rd@%h", a), readdata, m_read(a));
    check_eq("io_out", io_out, m_out);
    check_eq("irq", {7'b0, timer_irq}, {7'b0, m_flag});
    @(posedge clk);
    m_edge(we, a, wd, inv);
    #1;
  endtask

  logic [7:0] rd;
  logic [7:0] cur_in;

  initial begin
    cur_in = 8'h00;
    m_reset();

    // Power-on reset
    aluout = 8'hF2;
    #3;
    check_eq("por_io_out", io_out, 8'h00);
    check_eq("por_irq", {7'b0, timer_irq}, 8'h00);
    check_eq("por_cycle", readdata, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // RAM and write counter
    do_op(1, 8'h00, 8'hA5, cur_in, rd);
    do_op(1, 8'hBF, 8'h3C, cur_in, rd);
    do_op(0, 8'h00, 8'h00, cur_in, rd); check_eq("ram00", rd, 8'hA5);
    do_op(0, 8'hBF, 8'h00, cur_in, rd); check_eq("ramBF", rd, 8'h3C);
    do_op(0, 8'hF6, 8'h00, cur_in, rd); check_eq("wrcnt2", rd, 8'h02);
    do_op(1, 8'hC5, 8'h77, cur_in, rd);
    do_op(0, 8'hC5, 8'h00, cur_in, rd); check_eq("hole_C5", rd, 8'h00);
    do_op(0, 8'hF6, 8'h00, cur_in, rd); check_eq("wrcnt_hole", rd, 8'h02);

    // OUT / IN
    do_op(1, 8'hF0, 8'h5A, cur_in, rd);
    check_eq("io_out_5a", io_out, 8'h5A);
    cur_in = 8'h81;
    do_op(0, 8'hF1, 8'h00, cur_in, rd); check_eq("in_lag0", rd, 8'h00);
    do_op(0, 8'hF1, 8'h00, cur_in, rd); check_eq("in_lag1", rd, 8'h00);
    do_op(0, 8'hF1, 8'h00, cur_in, rd); check_eq("in_81", rd, 8'h81);

    // Timer period and expiry
    do_op(1, 8'hF3, 8'h03, cur_in, rd);
    do_op(0, 8'hF4, 8'h00, cur_in, rd); check_eq("cnt3", rd, 8'h03);
    do_op(0, 8'hF4, 8'h00, cur_in, rd); check_eq("cnt2", rd, 8'h02);
    check_eq("irq_early", {7'b0, timer_irq}, 8'h00);
    do_op(0, 8'hF4, 8'h00, cur_in, rd); check_eq("cnt1", rd, 8'h01);
    check_eq("irq_rise", {7'b0, timer_irq}, 8'h01);
    do_op(0, 8'hF4, 8'h00, cur_in, rd); check_eq("cnt_reload", rd, 8'h03);
    do_op(1, 8'hF5, 8'h01, cur_in, rd);
    check_eq("irq_clr", {7'b0, timer_irq}, 8'h00);

    // Clear colliding with expiry, then writing 0 to STATUS, then stop
    do_op(1, 8'hF3, 8'h00, cur_in, rd);
    do_op(1, 8'hF5, 8'h01, cur_in, rd);
    do_op(1, 8'hF3, 8'h02, cur_in, rd);
    do_op(0, 8'hF4, 8'h00, cur_in, rd);
    do_op(1, 8'hF5, 8'h01, cur_in, rd);
    check_eq("set_beats_clr", {7'b0, timer_irq}, 8'h01);
    do_op(1, 8'hF5, 8'h00, cur_in, rd);
    check_eq("w0_status", {7'b0, timer_irq}, 8'h01);
    do_op(1, 8'hF3, 8'h00, cur_in, rd);
    do_op(1, 8'hF5, 8'h01, cur_in, rd);
    repeat (8) do_op(0, 8'hF4, 8'h00, cur_in, rd);
    check_eq("stopped_cnt", rd, 8'h00);
    check_eq("stopped_irq", {7'b0, timer_irq}, 8'h00);

    // CYCLE wraps; writes to RO registers are ignored
    do_op(1, 8'hF2, 8'h40, cur_in, rd);
    do_op(1, 8'hF4, 8'h40, cur_in, rd);
    do_op(1, 8'hF6, 8'h40, cur_in, rd);
    repeat (260) do_op(0, 8'hF2, 8'h00, cur_in, rd);

    // Reset mid-run
    do_op(1, 8'h10, 8'h11, cur_in, rd);
    do_op(1, 8'hF0, 8'h77, cur_in, rd);
    do_op(1, 8'hF3, 8'h01, cur_in, rd);
    do_op(0, 8'hF4, 8'h00, cur_in, rd);
    do_op(0, 8'hF4, 8'h00, cur_in, rd);
    check_eq("pre_rst_irq", {7'b0, timer_irq}, 8'h01);
    check_eq("pre_rst_out", io_out, 8'h77);
    #2;
    reset = 1'b0;
    memwrite = 1'b1;
    writedata = 8'hEE;
    aluout = 8'hF2;
    #1;
    check_eq("rst_io_out", io_out, 8'h00);
    check_eq("rst_irq", {7'b0, timer_irq}, 8'h00);
    check_eq("rst_cycle", readdata, 8'h00);
    aluout = 8'hF4;
    #1;
    check_eq("rst_count", readdata, 8'h00);
    aluout = 8'h10;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    memwrite = 1'b0;
    do_op(0, 8'hF2, 8'h00, cur_in, rd); check_eq("cyc_first", rd, 8'h00);
    do_op(0, 8'hF2, 8'h00, cur_in, rd); check_eq("cyc_second", rd, 8'h01);
    do_op(0, 8'h10, 8'h00, cur_in, rd); check_eq("ram_kept", rd, 8'h11);

    // WRCNT saturation
    for (int i = 0; i < 260; i++) begin
      do_op(1, 8'($urandom_range(0, 191)), 8'($urandom), cur_in, rd);
    end
    do_op(0, 8'hF6, 8'h00, cur_in, rd); check_eq("wrcnt_sat", rd, 8'hFF);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [7:0] a;
      logic [7:0] wd;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      a = 8'($urandom_range(0, 191));
      else if (sel < 8) a = 8'($urandom_range(240, 255));
      else              a = 8'($urandom_range(0, 255));
      wd = (a == 8'hF3) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) cur_in = 8'($urandom);
      do_op(1'($urandom_range(0, 1)), a, wd, cur_in, rd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle `cpu`: it answers the cpu's data-port accesses (`aluout` address, `memwrite`, `writedata` → `readdata`). It holds a word-addressed data RAM and a small memory-mapped I/O page containing an output port, a synchronized input port, a cycle counter, an auto-reload timer with a sticky expiry flag, and a RAM write counter. It sits beside the instruction memory in the top level and is the only target of cpu loads and stores.

## Interface
- `DWIDTH`, 8: data and address width; address space is 2^DWIDTH words.
- `RAM_DEPTH`, 192: RAM words at addresses 0..RAM_DEPTH-1; must be ≤ 2^DWIDTH-16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; `reset`=0 clears all registers immediately.
- `memwrite` input 1: store strobe from cpu, sampled at the rising edge.
- `aluout` input DWIDTH: word address from cpu.
- `writedata` input DWIDTH: store data.
- `readdata` output DWIDTH: load data, combinational from `aluout`.
- `io_in` input DWIDTH: asynchronous external input.
- `io_out` output DWIDTH: registered output port.
- `timer_irq` output 1: equals the sticky timer expiry flag.

## Operation
- Address map, with MMIO base B = 2^DWIDTH-16 (0xF0 for DWIDTH=8):
  - 0..RAM_DEPTH-1 is RAM, R/W.
  - B+0 OUT: R/W, drives `io_out`.
  - B+1 IN: RO, 2-flop-synchronized `io_in`.
  - B+2 CYCLE: RO, free-running counter, +1 every cycle, wraps modulo 2^DWIDTH.
  - B+3 RELOAD: R/W timer reload value.
  - B+4 COUNT: RO timer count.
  - B+5 STATUS: bit0 = expiry flag, W1C; other bits read 0 and are ignored on write.
  - B+6 WRCNT: RO count of RAM writes, saturates at 2^DWIDTH-1.
  - All other addresses, B+7..B+15 included, read 0; writes are ignored.
- Writes to RO registers are ignored and do not disturb their counting.
- RAM: write at the edge when `memwrite`=1 and the address is in range. Contents are not reset; unwritten words read X.
- Timer, evaluated each edge:
  - A write to RELOAD loads both RELOAD and COUNT with `writedata`. This takes priority over decrement.
  - Otherwise, if COUNT>0, COUNT decrements by 1.
  - When COUNT goes 1→0, the flag is set and COUNT reloads from RELOAD in that same edge, so the period is RELOAD cycles.
  - RELOAD=0 stops the timer (COUNT stays 0, no expiry).
- Flag priority: set beats a W1C clear in the same cycle. Writing 0 to STATUS has no effect.
- WRCNT increments only on in-range RAM writes.

## Timing
- Load latency is 0 cycles: `readdata` follows `aluout` combinationally, as the single-cycle cpu requires.
- Store latency is 1 edge: the value is visible to a read on the next cycle.
- Reading any register returns its pre-edge value. Example: a CYCLE read returns N while the counter becomes N+1 at that edge.
- IN reflects `io_in` 2 edges after it changes (2-flop synchronizer).
- `io_out` and `timer_irq` are registers with no combinational path from inputs.
- While `reset`=0, all of the following hold 0: OUT, sync flops, CYCLE, RELOAD, COUNT, flag, WRCNT. So `io_out`=0 and `timer_irq`=0.
- Reset asserted mid-cycle: any store in flight is discarded for registers. The RAM write is suppressed while `reset`=0.
- After deassertion, CYCLE reads 0 on the first cycle and 1 on the second.

## Test plan
- RAM: write 0xA5 to 0x00 and 0x3C to 0xBF, read both → 0xA5, 0x3C. WRCNT reads 2. Write to 0xC5 → readback 0, WRCNT unchanged.
- OUT/IN: write 0x5A to 0xF0 → `io_out`=0x5A the next cycle. Drive `io_in`=0x81 → IN reads 0x81 starting 2 edges later.
- Timer: write 3 to 0xF3. COUNT reads 3,2,1 and then 3 again. `timer_irq` rises on the 3rd edge after the write.
- Flag clear: write 0x01 to 0xF5 → `timer_irq` falls. Clear on the same edge as a new expiry → flag stays 1. Writing 0 to RELOAD stops the timer.
- Counters: CYCLE wraps 0xFF→0x00. After 255 RAM writes WRCNT stays at 0xFF.
- Reset mid-run: pull `reset` low with the timer running and OUT=0x77 → `io_out`, `timer_irq`, CYCLE, COUNT read 0 immediately, without waiting for a clock edge.
